// File: rtl/inst_align_pkg.sv
// Shared definitions for the instruction aligner slice.
// Holds the datapath widths, the halfword-count/pointer types used by the
// ring buffer, the default reset PC, and the compressed-encoding test.
package inst_align_pkg;

  localparam int unsigned XLEN       = 64;  // PC and fetch word width
  localparam int unsigned ILEN       = 32;  // full instruction width
  localparam int unsigned HLEN       = 16;  // halfword width
  localparam int unsigned RING_DEPTH = 8;   // halfwords held by the aligner
  localparam int unsigned FETCH_HW   = 4;   // halfwords per fetch word

  typedef logic [3:0]      hw_cnt_t;  // 0..8 halfwords
  typedef logic [2:0]      hw_ptr_t;  // ring index, wraps modulo 8
  typedef logic [HLEN-1:0] hw_t;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input hw_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/hw_ring.sv
// 8-entry halfword circular queue for the instruction aligner.
// Ports:
//   clk, rst_n       clock, async active-low reset (empties the queue)
//   flush            drop all contents this cycle (head jumps to tail)
//   wr_en, wr_n      append wr_n (1..4) halfwords taken from wr_data[15:0] upward
//   wr_data          halfwords to append, lowest first
//   rd_en, rd_n      retire rd_n (1..2) halfwords from the head
//   rd_hw0, rd_hw1   halfwords at head and head+1
//   cnt              number of valid halfwords (0..8)
module hw_ring
  import inst_align_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            wr_en,
  input  hw_cnt_t         wr_n,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  hw_cnt_t         rd_n,
  output hw_t             rd_hw0,
  output hw_t             rd_hw1,
  output hw_cnt_t         cnt
);

  hw_t     mem [RING_DEPTH];
  hw_ptr_t head;
  hw_ptr_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= tail;
      cnt  <= '0;
    end else begin
      if (wr_en) tail <= tail + hw_ptr_t'(wr_n);
      if (rd_en) head <= head + hw_ptr_t'(rd_n);
      cnt <= cnt + (wr_en ? wr_n : '0) - (rd_en ? rd_n : '0);
    end
  end

  // Storage carries no reset: entries outside head..tail are never observed.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      for (int unsigned i = 0; i < FETCH_HW; i++) begin
        if (hw_cnt_t'(i) < wr_n)
          mem[tail + hw_ptr_t'(i)] <= wr_data[i*HLEN +: HLEN];
      end
    end
  end

  always_comb begin
    rd_hw0 = mem[head];
    rd_hw1 = mem[head + 3'd1];
  end

endmodule

// File: rtl/inst_align.sv
// Instruction aligner: turns 8-byte-aligned fetch words into a stream of
// 16-bit (compressed) and 32-bit instructions with their PCs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   fetch_valid/fetch_ready    fetch word handshake, fetch_data = hw3..hw0
//   redirect_valid/redirect_pc flush the queue and restart at redirect_pc
//   out_valid/out_ready        instruction handshake towards decode
//   out_inst, out_comp, out_pc head instruction, compressed flag, its PC
module inst_align
  import inst_align_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic            out_comp,
  output logic [XLEN-1:0] out_pc
);

  logic [1:0]      skip;     // halfwords of the next fetch word lying before the PC
  logic [XLEN-1:0] pc_q;
  hw_cnt_t         cnt;
  hw_cnt_t         wr_n;
  hw_cnt_t         rd_n;
  hw_t             hw0;
  hw_t             hw1;
  logic            comp;
  logic            enq;
  logic            deq;
  logic [XLEN-1:0] wr_data;

  always_comb begin
    comp = is_compressed(hw0);
    // rst_n gating keeps both handshakes closed for the whole reset window.
    fetch_ready = rst_n && !redirect_valid && (cnt <= 4'd4);
    out_valid   = rst_n && !redirect_valid &&
                  (((cnt >= 4'd1) && comp) || (cnt >= 4'd2));
    out_comp = comp;
    out_inst = comp ? {16'h0000, hw0} : {hw1, hw0};
    out_pc   = pc_q;
    enq      = fetch_valid && fetch_ready;
    deq      = out_valid && out_ready;
    wr_n     = 4'd4 - {2'b00, skip};
    rd_n     = comp ? 4'd1 : 4'd2;
    // Drop the skipped leading halfwords so the ring always writes from bit 0.
    wr_data  = fetch_data >> {skip, 4'b0000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= RESET_PC[2:1];
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      skip <= redirect_pc[2:1];
      pc_q <= redirect_pc & ~64'd1;
    end else begin
      if (enq) skip <= '0;
      if (deq) pc_q <= pc_q + (comp ? 64'd2 : 64'd4);
    end
  end

  hw_ring u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_n    (wr_n),
    .wr_data (wr_data),
    .rd_en   (deq),
    .rd_n    (rd_n),
    .rd_hw0  (hw0),
    .rd_hw1  (hw1),
    .cnt     (cnt)
  );

endmodule

// File: tb/tb_inst_align.sv
// Self-checking bench for inst_align: a directed vector table, hand-written
// corner sequences, and randomized traffic against a halfword-queue model.
module tb_inst_align;
  import inst_align_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [63:0] fetch_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_comp;
  logic [63:0] out_pc;

  int tests = 0;
  int fails = 0;

  inst_align #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_data     (fetch_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_comp       (out_comp),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: program-order queue of buffered halfwords, head PC, skip.
  logic [15:0] mq[$];
  logic [63:0] mpc;
  logic [1:0]  mskip;

  task automatic model_reset();
    logic [63:0] r;
    r = RPC;
    mq.delete();
    mpc   = r;
    mskip = r[2:1];
  endtask

  // Called just after a rising edge: apply inputs, compare at the falling edge,
  // then advance the model across the next rising edge.
  task automatic drive(input logic fv, input logic [63:0] fd, input logic ordy,
                       input logic rv, input logic [63:0] rpc);
    logic e_fr, e_ov, e_c;
    logic [63:0] ei;
    fetch_valid    = fv;
    fetch_data     = fd;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    e_c  = (mq.size() > 0) && (mq[0][1:0] != 2'b11);
    e_fr = !rv && (mq.size() <= 4);
    e_ov = !rv && (((mq.size() >= 1) && e_c) || (mq.size() >= 2));
    check("fetch_ready", fetch_ready, e_fr);
    check("out_valid", out_valid, e_ov);
    check("out_pc", out_pc, mpc);
    if (e_ov) begin
      ei = e_c ? {48'h0, mq[0]} : {32'h0, mq[1], mq[0]};
      check("out_inst", out_inst, ei);
      check("out_comp", out_comp, e_c);
    end
    @(posedge clk);
    if (rv) begin
      mq.delete();
      mpc   = rpc & ~64'd1;
      mskip = rpc[2:1];
    end else begin
      if (e_ov && ordy) begin
        mpc = mpc + (e_c ? 64'd2 : 64'd4);
        void'(mq.pop_front());
        if (!e_c) void'(mq.pop_front());
      end
      if (fv && e_fr) begin
        for (int k = int'(mskip); k < 4; k++) mq.push_back(fd[k*16 +: 16]);
        mskip = 2'd0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_valid    = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rst_fetch_ready", fetch_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, RPC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        fv;
    logic [63:0] fd;
    logic        ordy;
    logic        rv;
    logic [63:0] rpc;
    logic        e_fr;
    logic        e_ov;
    logic [31:0] e_inst;
    logic        e_comp;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Reset, straddling 32-bit instruction, and fill-limit vectors.
    tbl[0]  = '{1'b1, 64'h0000_0013_4501_4505, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h8000_0000};
    tbl[1]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 32'h0000_4505, 1'b1, 64'h8000_0000};
    tbl[2]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 32'h0000_4501, 1'b1, 64'h8000_0002};
    tbl[3]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 64'h8000_0004};
    tbl[4]  = '{1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 64'h8000_0006, 1'b0, 1'b0, 32'h0, 1'b0, 64'h8000_0008};
    tbl[5]  = '{1'b1, 64'h0513_1111_2222_3333, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h8000_0006};
    tbl[6]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h8000_0006};
    tbl[7]  = '{1'b1, 64'h4505_4505_0001_0000, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h8000_0006};
    tbl[8]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_0513, 1'b0, 64'h8000_0006};
    tbl[9]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 64'h8000_000A};
    tbl[10] = '{1'b0, 64'h0,                   1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 32'h0000_4505, 1'b1, 64'h8000_000C};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      fetch_valid    = tbl[i].fv;
      fetch_data     = tbl[i].fd;
      out_ready      = tbl[i].ordy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("vec%0d_fetch_ready", i), fetch_ready, tbl[i].e_fr);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].e_pc);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d_out_inst", i), out_inst, tbl[i].e_inst);
        check($sformatf("vec%0d_out_comp", i), out_comp, tbl[i].e_comp);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure with pointer wrap: move head/tail to 4, then fill to 8.
    do_reset();
    drive(1'b1, 64'h0009_0009_0009_0009, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    drive(1'b1, 64'h0041_0031_0021_0011, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 64'h0081_0071_0061_0051, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 64'h00C1_00B1_00A1_0091, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 64'h0101_00F1_00E1_00D1, 1'b0, 1'b0, 64'h0);
    check("bp_full_fetch_ready", fetch_ready, 1'b0);
    check("bp_full_cnt", dut.u_ring.cnt, 4'd8);
    for (int i = 0; i < 8; i++) begin
      fetch_valid = 1'b0;
      out_ready   = 1'b1;
      #1;
      check($sformatf("bp_drain%0d_inst", i), out_inst, 32'h11 + 32'h10 * i);
      #2;
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    end
    check("bp_empty_out_valid", out_valid, 1'b0);

    // Redirect while six halfwords are buffered and a fetch is offered.
    do_reset();
    drive(1'b0, 64'h0, 1'b0, 1'b1, 64'h8000_0004);
    drive(1'b1, 64'h0005_0005_DEAD_DEAD, 1'b0, 1'b0, 64'h0);
    drive(1'b1, 64'h0009_0009_0009_0009, 1'b0, 1'b0, 64'h0);
    check("rd_cnt6", dut.u_ring.cnt, 4'd6);
    drive(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, 64'h8000_1002);
    drive(1'b1, 64'h0000_0000_4509_1111, 1'b0, 1'b0, 64'h0);
    fetch_valid = 1'b0;
    #1;
    check("rd_out_valid", out_valid, 1'b1);
    check("rd_out_inst", out_inst, 32'h0000_4509);
    check("rd_out_pc", out_pc, 64'h8000_1002);
    for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);

    // Reset with the lower half of a 32-bit instruction buffered.
    do_reset();
    drive(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_0006);
    drive(1'b1, 64'h0513_0000_0000_0000, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    rst_n = 1'b0;
    #2;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_fetch_ready", fetch_ready, 1'b0);
    check("mrst_out_pc", out_pc, RPC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 64'h0001_0001_0001_4505, 1'b0, 1'b0, 64'h0);
    fetch_valid = 1'b0;
    #1;
    check("mrst_first_inst", out_inst, 32'h0000_4505);
    check("mrst_first_pc", out_pc, RPC);
    check("mrst_first_comp", out_comp, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);

    // Randomized traffic against the model, including redirects near PC wrap.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        fv, ordy, rv;
      logic [63:0] fd, rpc;
      fv   = ($urandom_range(0, 3) != 0);
      fd   = {$urandom, $urandom};
      ordy = ($urandom_range(0, 2) != 0);
      rv   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else                            rpc = {32'h0, $urandom};
      drive(fv, fd, ordy, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
